// File: rtl/i2s_tdm_clkgen.sv
// I2S / left-justified / TDM serial clock generator.
// Everything runs in the clk domain. BCK and LRCK/FSYNC are registered data
// outputs, and one-cycle strobes mark each BCK edge for downstream logic.
// A phase counter divides clk into BCK periods. Bit and slot counters advance
// only on bck_fall. A stop request is honoured only at a frame boundary, so
// frames are never truncated.
module i2s_tdm_clkgen #(
    parameter int BCK_DIV   = 16,  // clk cycles per BCK, even, >= 4
    parameter int SLOT_BITS = 32,  // BCK periods per slot, >= 2
    parameter int NUM_SLOTS = 2,   // slots per frame, >= 2 (even for MODE < 2)
    parameter int MODE      = 0    // 0 = I2S, 1 = left-justified, 2 = TDM pulse
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    output logic                         bck,
    output logic                         lrck,
    output logic                         bck_rise,
    output logic                         bck_fall,
    output logic                         frame_start,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
    output logic                         busy
);
    localparam int PW = $clog2(BCK_DIV);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int BW = $clog2(SLOT_BITS);

    localparam logic [PW-1:0] PH_LAST     = PW'(BCK_DIV - 1);
    localparam logic [PW-1:0] PH_PRE_RISE = PW'(BCK_DIV / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(SLOT_BITS - 1);
    localparam logic [SW-1:0] SLOT_LAST   = SW'(NUM_SLOTS - 1);
    localparam logic [SW-1:0] SLOT_HALF   = SW'(NUM_SLOTS / 2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          r_state, w_state_nx;
    logic [PW-1:0]   r_ph,    w_ph_nx;
    logic [BW-1:0]   r_bit,   w_bit_nx;
    logic [SW-1:0]   r_slot,  w_slot_nx;
    logic            r_bck,   w_bck_nx;
    logic            r_lrck,  w_lrck_nx;
    logic            r_rise,  w_rise_nx;
    logic            r_fall,  w_fall_nx;
    logic            r_fs,    w_fs_nx;
    logic            r_busy,  w_busy_nx;

    logic            w_wrap;       // last clk of the current BCK period
    logic            w_bit_last;
    logic            w_frame_end;  // last clk of the last bit of the frame
    logic [BW-1:0]   w_bit_inc;    // bit position after the next bck_fall
    logic [SW-1:0]   w_slot_inc;   // slot position after the next bck_fall

    // LRCK level to present for the BCK period of bit b, slot s.
    // MODE 0 looks one bit ahead, so the WS edge leads the MSB by one BCK.
    function automatic logic lrck_for(input logic [BW-1:0] b, input logic [SW-1:0] s);
        logic [SW-1:0] s_nx;
        s_nx = s;
        if (b == BIT_LAST)
            s_nx = (s == SLOT_LAST) ? '0 : s + 1'b1;
        if (MODE == 0)
            return s_nx >= SLOT_HALF;
        else if (MODE == 1)
            return s < SLOT_HALF;
        else
            return (b == '0) && (s == '0);
    endfunction

    assign w_wrap      = (r_ph == PH_LAST);
    assign w_bit_last  = (r_bit == BIT_LAST);
    assign w_frame_end = w_wrap && w_bit_last && (r_slot == SLOT_LAST);
    assign w_bit_inc   = w_bit_last ? '0 : r_bit + 1'b1;
    assign w_slot_inc  = !w_bit_last ? r_slot :
                         (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;

    // Next state and next output values. A stop is taken only at frame end.
    always_comb begin
        w_state_nx = r_state;
        w_ph_nx    = r_ph;
        w_bit_nx   = r_bit;
        w_slot_nx  = r_slot;
        w_bck_nx   = r_bck;
        w_lrck_nx  = r_lrck;
        w_busy_nx  = r_busy;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        w_fs_nx    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nx = S_RUN;
                    w_ph_nx    = '0;
                    w_bit_nx   = '0;
                    w_slot_nx  = '0;
                    w_bck_nx   = 1'b0;
                    w_fall_nx  = 1'b1;
                    w_fs_nx    = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_lrck_nx  = lrck_for('0, '0);
                end
            end
            S_RUN, S_DRAIN: begin
                w_state_nx = en ? S_RUN : S_DRAIN;
                w_ph_nx    = w_wrap ? '0 : r_ph + 1'b1;
                if (r_ph == PH_PRE_RISE) begin
                    w_bck_nx  = 1'b1;
                    w_rise_nx = 1'b1;
                end
                if (w_wrap) begin
                    if (w_frame_end && !en) begin
                        // Frame finished with no run request: go quiet.
                        w_state_nx = S_IDLE;
                        w_bit_nx   = '0;
                        w_slot_nx  = '0;
                        w_bck_nx   = 1'b0;
                        w_lrck_nx  = 1'b0;
                        w_busy_nx  = 1'b0;
                    end else begin
                        w_bck_nx   = 1'b0;
                        w_fall_nx  = 1'b1;
                        w_fs_nx    = w_frame_end;
                        w_bit_nx   = w_bit_inc;
                        w_slot_nx  = w_slot_inc;
                        w_lrck_nx  = lrck_for(w_bit_inc, w_slot_inc);
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // Counters and registered outputs. Reset clears them immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ph   <= '0;
            r_bit  <= '0;
            r_slot <= '0;
            r_bck  <= 1'b0;
            r_lrck <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_fs   <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_ph   <= w_ph_nx;
            r_bit  <= w_bit_nx;
            r_slot <= w_slot_nx;
            r_bck  <= w_bck_nx;
            r_lrck <= w_lrck_nx;
            r_rise <= w_rise_nx;
            r_fall <= w_fall_nx;
            r_fs   <= w_fs_nx;
            r_busy <= w_busy_nx;
        end
    end

    assign bck         = r_bck;
    assign lrck        = r_lrck;
    assign bck_rise    = r_rise;
    assign bck_fall    = r_fall;
    assign frame_start = r_fs;
    assign slot_idx    = r_slot;
    assign bit_idx     = r_bit;
    assign busy        = r_busy;

endmodule

// File: tb/tb_i2s_tdm_clkgen.sv
// Bench for i2s_tdm_clkgen. It drives three instances from a shared clk, reset
// and en:
//   inst 0: I2S, 32-bit slots, 2 slots
//   inst 1: left-justified, 16-bit slots, 8 slots
//   inst 2: TDM pulse, 16-bit slots, 8 slots
// The reference tracks only "running" and the clk offset within the frame.
// Every output is derived from that offset arithmetically.
module tb_i2s_tdm_clkgen;
    logic clk = 1'b0;
    logic reset_n;
    logic en;

    logic [2:0] bck, lrck, rise, fall, fs, busy;
    logic [0:0] a_slot;
    logic [4:0] a_bit;
    logic [2:0] b_slot, c_slot;
    logic [3:0] b_bit,  c_bit;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       bck;
        logic       lrck;
        logic       rise;
        logic       fall;
        logic       fs;
        logic       busy;
        logic [7:0] sidx;
        logic [7:0] bidx;
    } obs_t;

    always #5 clk = ~clk;

    i2s_tdm_clkgen #(.BCK_DIV(16), .SLOT_BITS(32), .NUM_SLOTS(2), .MODE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en),
        .bck(bck[0]), .lrck(lrck[0]), .bck_rise(rise[0]), .bck_fall(fall[0]),
        .frame_start(fs[0]), .slot_idx(a_slot), .bit_idx(a_bit), .busy(busy[0]));

    i2s_tdm_clkgen #(.BCK_DIV(16), .SLOT_BITS(16), .NUM_SLOTS(8), .MODE(1)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en),
        .bck(bck[1]), .lrck(lrck[1]), .bck_rise(rise[1]), .bck_fall(fall[1]),
        .frame_start(fs[1]), .slot_idx(b_slot), .bit_idx(b_bit), .busy(busy[1]));

    i2s_tdm_clkgen #(.BCK_DIV(16), .SLOT_BITS(16), .NUM_SLOTS(8), .MODE(2)) u_c (
        .clk(clk), .reset_n(reset_n), .en(en),
        .bck(bck[2]), .lrck(lrck[2]), .bck_rise(rise[2]), .bck_fall(fall[2]),
        .frame_start(fs[2]), .slot_idx(c_slot), .bit_idx(c_bit), .busy(busy[2]));

    function automatic int cfg_sb(input int k);   return (k == 0) ? 32 : 16; endfunction
    function automatic int cfg_ns(input int k);   return (k == 0) ? 2 : 8;   endfunction
    function automatic int cfg_mode(input int k); return k;                  endfunction
    function automatic int cfg_div(input int k);  return (k >= 0) ? 16 : 0;  endfunction

    // Reference: outputs as a pure function of the clk offset within a frame.
    function automatic obs_t model_obs(input int k, input bit on, input int t);
        obs_t o;
        int div, sb, ns, pos, gbit, nb;
        o = '0;
        if (on) begin
            div  = cfg_div(k);
            sb   = cfg_sb(k);
            ns   = cfg_ns(k);
            pos  = t % div;
            gbit = t / div;
            o.busy = 1'b1;
            o.bck  = (pos >= div / 2);
            o.rise = (pos == div / 2);
            o.fall = (pos == 0);
            o.fs   = (t == 0);
            o.sidx = 8'(gbit / sb);
            o.bidx = 8'(gbit % sb);
            case (cfg_mode(k))
                0: begin
                    nb     = (gbit + 1) % (sb * ns);
                    o.lrck = ((nb / sb) >= ns / 2);
                end
                1:       o.lrck = ((gbit / sb) < ns / 2);
                default: o.lrck = (gbit == 0);
            endcase
        end
        return o;
    endfunction

    function automatic obs_t mk(input logic b, input logic l, input logic r, input logic f,
                                input logic s, input logic u, input int si, input int bi);
        obs_t o;
        o.bck  = b; o.lrck = l; o.rise = r; o.fall = f; o.fs = s; o.busy = u;
        o.sidx = 8'(si);
        o.bidx = 8'(bi);
        return o;
    endfunction

    bit m_on [3];
    int m_t  [3];

    // Reference state: start on en, wrap or stop at the end of each frame.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                m_on[k] <= 1'b0;
                m_t[k]  <= 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (!m_on[k]) begin
                    if (en) begin
                        m_on[k] <= 1'b1;
                        m_t[k]  <= 0;
                    end
                end else if (m_t[k] == cfg_div(k) * cfg_sb(k) * cfg_ns(k) - 1) begin
                    m_t[k] <= 0;
                    if (!en) m_on[k] <= 1'b0;
                end else begin
                    m_t[k] <= m_t[k] + 1;
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the reference.
    always @(negedge clk) begin
        obs_t got, exp;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       got = mk(bck[0], lrck[0], rise[0], fall[0], fs[0], busy[0], int'(a_slot), int'(a_bit));
                1:       got = mk(bck[1], lrck[1], rise[1], fall[1], fs[1], busy[1], int'(b_slot), int'(b_bit));
                default: got = mk(bck[2], lrck[2], rise[2], fall[2], fs[2], busy[2], int'(c_slot), int'(c_bit));
            endcase
            exp = model_obs(k, m_on[k], m_t[k]);
            n_cmp = n_cmp + 1;
            if (got !== exp) begin
                n_err = n_err + 1;
                $display("FAIL cycle_model inst%0d t=%0d got=%h expected=%h", k, m_t[k], got, exp);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp = n_cmp + 1;
        if (got != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        int a_rise, a_fs, a_bit0, b_fs, c_fs, b_hi, c_hi, a_lr_rise, a_lr_fall;
        logic prev_a_lr;

        en      = 1'b0;
        reset_n = 1'b0;
        run(3);
        check("reset_outputs", int'({bck, lrck, rise, fall, fs, busy}), 0);
        check("reset_indices", int'({a_slot, a_bit, b_slot, b_bit, c_slot, c_bit}), 0);
        reset_n = 1'b1;
        run(2);
        check("idle_busy", int'(busy), 0);

        // Start: en is sampled at the next edge, and all strobes appear one cycle later.
        en = 1'b1;
        run(1);
        check("start_frame_start", int'(fs), 7);
        check("start_bck_fall", int'(fall), 7);
        check("start_busy", int'(busy), 7);
        check("start_bck", int'(bck), 0);
        check("start_lrck", int'(lrck), 3'b110);

        // Two frames of inst 0, one frame of inst 1 and inst 2, starting at offset 0.
        a_rise = 0; a_fs = 0; a_bit0 = 0; b_fs = 0; c_fs = 0; b_hi = 0; c_hi = 0;
        a_lr_rise = -1; a_lr_fall = -1;
        prev_a_lr = lrck[0];
        for (int i = 0; i < 2048; i++) begin
            if (i < 1024 && rise[0]) a_rise++;
            if (fs[0]) a_fs++;
            if (fall[0] && a_bit == 5'd0) a_bit0++;
            if (fs[1]) b_fs++;
            if (fs[2]) c_fs++;
            if (lrck[1]) b_hi++;
            if (lrck[2]) c_hi++;
            if (lrck[0] && !prev_a_lr && a_lr_rise < 0) a_lr_rise = i;
            if (!lrck[0] && prev_a_lr && a_lr_fall < 0) a_lr_fall = i;
            prev_a_lr = lrck[0];
            run(1);
        end
        check("a_bck_rise_per_frame", a_rise, 64);
        check("a_frame_starts_in_2048", a_fs, 2);
        check("a_bit0_falls_in_2048", a_bit0, 4);
        // Offsets from frame_start: slot 0 bit 31 = 31*16 and slot 1 bit 31 = 63*16.
        check("a_lrck_rise_offset", a_lr_rise, 496);
        check("a_lrck_fall_offset", a_lr_fall, 1008);
        check("b_lrck_high_clks", b_hi, 1024);
        check("c_lrck_high_clks", c_hi, 16);
        check("b_frame_starts", b_fs, 1);
        check("c_frame_starts", c_fs, 1);
        check("a_frame3_start", int'(fs[0]), 1);

        // Drop en mid-frame and raise it again: the next frame follows with no gap.
        run(80);
        en = 1'b0;
        run(520);
        en = 1'b1;
        run(424);
        check("resume_no_gap", int'(fs[0]), 1);

        // Drop en at slot 0 bit 5: the frame completes and busy falls 1024 clk after frame_start.
        run(80);
        en = 1'b0;
        k = 0;
        while (busy[0] && k < 4000) begin
            k++;
            run(1);
        end
        check("stop_busy_low_delay", k, 944);
        check("stop_a_quiet", int'({bck[0], lrck[0], rise[0], fall[0], a_slot, a_bit}), 0);
        check("stop_all_idle", int'(busy), 0);
        run(50);
        check("idle_no_strobes", int'({rise, fall, fs, bck, lrck}), 0);

        // Restart from idle: the first frame matches the power-on first frame.
        en = 1'b1;
        run(1);
        check("restart_frame_start", int'(fs), 7);
        check("restart_lrck", int'(lrck), 3'b110);

        // Asynchronous reset mid-slot clears outputs without waiting for a clock edge.
        run(357);
        #1 reset_n = 1'b0;
        #1 check("async_reset_clear", int'({bck, lrck, rise, fall, fs, busy}), 0);
        run(2);
        reset_n = 1'b1;
        run(1);
        check("post_reset_frame_start", int'(fs), 7);

        // Random en activity checked by the reference.
        for (int s = 0; s < 40; s++) begin
            en = 1'($urandom_range(0, 1));
            run(int'($urandom_range(1, 400)));
        end
        en = 1'b0;
        run(2100);
        check("final_idle", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
